// File: rtl/vga_fb_arbiter.sv
// VGA framebuffer arbiter: one single-port synchronous RAM shared between the display
// fetch path and a single pixel writer. The display owns the port during active video;
// writes are held in a one-deep latch and issued only in blanking, with a req/ack handshake.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FB_DEPTH = 307200,
  parameter int unsigned STALL_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inDisplayArea,
  input  logic              vga_v_sync,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StAck
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  disp_addr_q, disp_addr_d;
  logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]  lat_data_q, lat_data_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               pix_valid_q;

  // Display fetch address: vsync clear wins over the per-pixel increment.
  always_comb begin
    disp_addr_d = disp_addr_q;
    if (!vga_v_sync) begin
      disp_addr_d = '0;
    end else if (inDisplayArea) begin
      disp_addr_d = (disp_addr_q == LastAddr) ? '0 : disp_addr_q + 1'b1;
    end
  end

  // Write FSM next state, latch update, handshake outputs and stall accounting.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    stall_d    = stall_q;
    mem_we     = 1'b0;
    wr_ack     = 1'b0;
    wr_busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          lat_addr_d = wr_addr;
          lat_data_d = wr_data;
          state_d    = StPend;
        end
      end
      StPend: begin
        wr_busy = 1'b1;
        if (!inDisplayArea) begin
          // Port is free during blanking: commit the latched word now.
          mem_we  = 1'b1;
          state_d = StAck;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      StAck: begin
        wr_busy = 1'b1;
        wr_ack  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // RAM port mux: display address during active video, latched write address otherwise.
  always_comb begin
    mem_addr  = inDisplayArea ? disp_addr_q : lat_addr_q;
    mem_wdata = lat_data_q;
  end

  // State registers for the fetch counter, write FSM, latch and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      disp_addr_q <= '0;
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      stall_q     <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_addr_q <= disp_addr_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      stall_q     <= stall_d;
      pix_valid_q <= inDisplayArea;
    end
  end

  // The RAM's read register supplies the one-cycle delay, so the data is only gated here.
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_valid_q ? mem_rdata : '0;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed handshake/display scenarios plus a randomized run,
// checked every cycle against a transaction-level model and a few literal expectations.
module tb_vga_fb_arbiter;

  localparam int unsigned AW    = 19;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 700;
  localparam int unsigned SW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ida = 1'b0;
  logic          vsync = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, wr_busy, mem_we, pix_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, pix_data;
  logic [SW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .FB_DEPTH(DEPTH),
    .STALL_W (SW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inDisplayArea(ida),
    .vga_v_sync   (vsync),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .wr_busy      (wr_busy),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .stall_cnt    (stall_cnt)
  );

  // Framebuffer RAM: unwritten words read back as address[7:0].
  logic [DW-1:0] ram [1024];
  bit            ram_v [1024];
  logic [DW-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[9:0]]   <= mem_wdata;
      ram_v[mem_addr[9:0]] <= 1'b1;
    end
    rdata_q <= ram_v[mem_addr[9:0]] ? ram[mem_addr[9:0]] : mem_addr[7:0];
  end
  assign mem_rdata = rdata_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding write transaction, a pixel counter modulo the frame size,
  // and a shadow of the framebuffer contents.
  int            m_disp;
  bit            m_pend, m_ack, m_pv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_pd;
  int            m_stall;
  logic [DW-1:0] m_ram [1024];
  bit            m_wr [1024];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_disp  <= 0;
      m_pend  <= 1'b0;
      m_ack   <= 1'b0;
      m_pv    <= 1'b0;
      m_pd    <= '0;
      m_addr  <= '0;
      m_data  <= '0;
      m_stall <= 0;
    end else begin
      m_disp <= !vsync ? 0 : (ida ? (m_disp + 1) % DEPTH : m_disp);
      m_pv   <= ida;
      m_pd   <= m_wr[m_disp] ? m_ram[m_disp] : 8'(m_disp);
      if (m_ack) begin
        m_ack <= 1'b0;
      end else if (m_pend) begin
        if (!ida) begin
          m_ram[m_addr[9:0]] <= m_data;
          m_wr[m_addr[9:0]]  <= 1'b1;
          m_pend <= 1'b0;
          m_ack  <= 1'b1;
        end else if (m_stall < (1 << SW) - 1) begin
          m_stall <= m_stall + 1;
        end
      end else if (wr_req) begin
        m_pend <= 1'b1;
        m_addr <= wr_addr;
        m_data <= wr_data;
      end
    end
  end

  // Monitor totals used by the directed checks.
  int            n_ack = 0, n_we = 0, n_busy = 0, ack_t = 0, we_t = 0;
  logic [AW-1:0] we_a = '0;
  logic [DW-1:0] we_d = '0;
  logic [DW-1:0] pq [$];

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_we", 32'(mem_we), 32'(m_pend && !ida));
      chk("mem_addr", 32'(mem_addr), ida ? 32'(m_disp) : 32'(m_addr));
      if (mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
      if (ida) chk("we_in_display", 32'(mem_we), 32'(0));
      chk("wr_ack", 32'(wr_ack), 32'(m_ack));
      chk("wr_busy", 32'(wr_busy), 32'(m_pend || m_ack));
      chk("pix_valid", 32'(pix_valid), 32'(m_pv));
      chk("pix_data", 32'(pix_data), m_pv ? 32'(m_pd) : 32'(0));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (wr_ack) begin
        n_ack++;
        ack_t = cyc;
      end
      if (mem_we) begin
        n_we++;
        we_t = cyc;
        we_a = mem_addr;
        we_d = mem_wdata;
      end
      if (wr_busy) n_busy++;
      if (pix_valid) pq.push_back(pix_data);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Holds wr_req until an ack is seen, then drops it the following cycle.
  task automatic wait_ack();
    bit got = 1'b0;
    for (int k = 0; k < 1000 && !got; k++) begin
      @(negedge clk);
      if (wr_ack === 1'b1) got = 1'b1;
      nxt();
    end
    wr_req = 1'b0;
    chk("ack_seen", 32'(got), 32'(1));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int t_req);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    t_req   = cyc;
    wait_ack();
  endtask

  initial begin
    int t0, a0, w0, b0, blank_t, run;
    bit drop;

    // Reset values.
    nxt();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_wr_ack", 32'(wr_ack), 32'(0));
    chk("rst_wr_busy", 32'(wr_busy), 32'(0));
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_pix_data", 32'(pix_data), 32'(0));
    chk("rst_stall", 32'(stall_cnt), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    nxt();
    rst = 1'b0;
    repeat (3) nxt();

    // Write during blanking.
    a0 = n_ack; w0 = n_we; b0 = n_busy;
    do_write(19'h00010, 8'hA5, t0);
    repeat (2) nxt();
    chk("blank_ack_latency", 32'(ack_t - t0), 32'(2));
    chk("blank_we_then_ack", 32'(ack_t - we_t), 32'(1));
    chk("blank_we_count", 32'(n_we - w0), 32'(1));
    chk("blank_ack_count", 32'(n_ack - a0), 32'(1));
    chk("blank_we_addr", 32'(we_a), 32'h10);
    chk("blank_we_data", 32'(we_d), 32'hA5);
    chk("blank_busy_cycles", 32'(n_busy - b0), 32'(2));

    // Write requested during active video, held off for 100 cycles.
    w0 = n_we;
    ida = 1'b1; wr_req = 1'b1; wr_addr = 19'h00020; wr_data = 8'h5A;
    repeat (101) nxt();
    chk("stall_no_we", 32'(n_we - w0), 32'(0));
    ida = 1'b0;
    blank_t = cyc;
    wait_ack();
    chk("stall_cnt_100", 32'(stall_cnt), 32'(100));
    chk("stall_we_first_blank", 32'(we_t - blank_t), 32'(0));
    chk("stall_ack_next", 32'(ack_t - blank_t), 32'(1));

    // Reset while a write is pending.
    a0 = n_ack; w0 = n_we;
    ida = 1'b1; wr_req = 1'b1; wr_addr = 19'h00030; wr_data = 8'h11;
    repeat (2) nxt();
    rst = 1'b1; wr_req = 1'b0;
    repeat (2) nxt();
    rst = 1'b0; ida = 1'b0;
    repeat (5) nxt();
    chk("rstpend_no_ack", 32'(n_ack - a0), 32'(0));
    chk("rstpend_no_we", 32'(n_we - w0), 32'(0));
    chk("rstpend_stall", 32'(stall_cnt), 32'(0));
    chk("rstpend_busy", 32'(wr_busy), 32'(0));

    // Back-to-back requests with wr_req held for 9 blank cycles.
    a0 = n_ack; w0 = n_we;
    wr_req = 1'b1; wr_addr = 19'h00040; wr_data = 8'h77;
    repeat (9) nxt();
    wr_req = 1'b0;
    repeat (3) nxt();
    chk("b2b_acks", 32'(n_ack - a0), 32'(3));
    chk("b2b_wes", 32'(n_we - w0), 32'(3));
    chk("b2b_stall", 32'(stall_cnt), 32'(0));

    // One 640-pixel line after vsync.
    vsync = 1'b0;
    nxt();
    vsync = 1'b1;
    pq.delete();
    ida = 1'b1;
    repeat (640) nxt();
    ida = 1'b0;
    repeat (3) nxt();
    chk("line_pix_count", 32'(pq.size()), 32'(640));
    if (pq.size() == 640) begin
      chk("line_pix_0", 32'(pq[0]), 32'h00);
      chk("line_pix_1", 32'(pq[1]), 32'h01);
      chk("line_pix_10", 32'(pq[16]), 32'hA5);
      chk("line_pix_40", 32'(pq[64]), 32'h77);
      chk("line_pix_7f", 32'(pq[127]), 32'h7F);
      chk("line_pix_300", 32'(pq[300]), 32'h2C);
    end
    chk("blank_pix_data", 32'(pix_data), 32'(0));

    // Next line runs past the end of the frame and wraps.
    pq.delete();
    ida = 1'b1;
    repeat (100) nxt();
    ida = 1'b0;
    repeat (3) nxt();
    chk("wrap_pix_count", 32'(pq.size()), 32'(100));
    if (pq.size() == 100) begin
      chk("wrap_pix_last", 32'(pq[59]), 32'hBB);
      chk("wrap_pix_zero", 32'(pq[60]), 32'h00);
      chk("wrap_pix_one", 32'(pq[61]), 32'h01);
    end

    // vsync clears the fetch address.
    vsync = 1'b0;
    nxt();
    vsync = 1'b1;
    ida = 1'b1;
    @(negedge clk);
    chk("vsync_addr_zero", 32'(mem_addr), 32'(0));
    nxt();
    ida = 1'b0;
    nxt();

    // Randomized video timing and writer traffic, with one reset mid-run.
    run = 0;
    drop = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        ida = ~ida;
        run = ida ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
      end
      run--;
      vsync = ($urandom_range(0, 63) != 0);
      if (drop) begin
        wr_req = 1'b0;
        drop = 1'b0;
      end else if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(0, 1023));
        wr_data = 8'($urandom);
      end
      if (i == 2000) begin
        rst = 1'b1;
        wr_req = 1'b0;
      end
      if (i == 2002) rst = 1'b0;
      @(negedge clk);
      if (wr_ack === 1'b1) drop = 1'b1;
      nxt();
    end
    wr_req = 1'b0;
    ida = 1'b0;
    repeat (4) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
